// File: rtl/fp32_divider_iterative.sv
// Sequential IEEE 754 single-precision divider: delta = alpha / bravo.
// Radix-2 restoring division, one quotient bit per cycle, round to nearest even,
// subnormal inputs and outputs supported, valid/ready handshake on both sides.
module fp32_divider_iterative (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alpha,
  input  logic [31:0] bravo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] delta,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

  state_t state, state_next;

  logic [31:0]       a_q, b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [24:0]       rem_q;
  logic [23:0]       mant_b_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;

  // Leading-zero count of a 24-bit mantissa (used to normalise subnormals).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!hit) begin
        if (m[i]) hit = 1'b1;
        else      n   = n + 5'd1;
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Special-operand classification on the live inputs (used at acceptance)
  // ---------------------------------------------------------------------------
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, in_sign;
  logic        special, spec_dbz;
  logic [31:0] spec_word;

  // Classify operands and build the special-case result word.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    in_sign   = alpha[31] ^ bravo[31];
    a_nan     = (&alpha[30:23]) & (|alpha[22:0]);
    b_nan     = (&bravo[30:23]) & (|bravo[22:0]);
    a_inf     = (&alpha[30:23]) & ~(|alpha[22:0]);
    b_inf     = (&bravo[30:23]) & ~(|bravo[22:0]);
    a_zero    = ~(|alpha[30:0]);
    b_zero    = ~(|bravo[30:0]);
    special   = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    spec_dbz  = 1'b0;
    spec_word = {in_sign, 31'h0};
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_word = {in_sign, 8'hFF, 23'h7FFFFF};
    end else if (a_inf) begin
      spec_word = {in_sign, 8'hFF, 23'h0};
    end else if (b_zero) begin
      spec_word = {in_sign, 8'hFF, 23'h0};
      spec_dbz  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // NORM: unpack registered operands, normalise subnormals, pre-align dividend
  // ---------------------------------------------------------------------------
  logic [23:0]       mant_ra, mant_rb, mant_na, mant_nb;
  logic signed [9:0] exp_ra, exp_rb, exp_na, exp_nb, norm_exp;
  logic [4:0]        lz_a, lz_b;
  logic [24:0]       norm_rem;

  // Normalised mantissas and biased quotient exponent.
  always_comb begin
    mant_ra  = (a_q[30:23] == 8'd0) ? {1'b0, a_q[22:0]} : {1'b1, a_q[22:0]};
    mant_rb  = (b_q[30:23] == 8'd0) ? {1'b0, b_q[22:0]} : {1'b1, b_q[22:0]};
    exp_ra   = (a_q[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, a_q[30:23]});
    exp_rb   = (b_q[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, b_q[30:23]});
    lz_a     = lzc24(mant_ra);
    lz_b     = lzc24(mant_rb);
    mant_na  = mant_ra << lz_a;
    mant_nb  = mant_rb << lz_b;
    exp_na   = exp_ra - $signed({5'b00000, lz_a});
    exp_nb   = exp_rb - $signed({5'b00000, lz_b});
    norm_exp = exp_na - exp_nb + 10'sd127;
    norm_rem = {1'b0, mant_na};
    // Guarantee the first quotient bit is 1 so q[25] is the hidden bit.
    if (mant_na < mant_nb) begin
      norm_rem = {mant_na, 1'b0};
      norm_exp = norm_exp - 10'sd1;
    end
  end

  // ---------------------------------------------------------------------------
  // DIV: one restoring step per cycle
  // ---------------------------------------------------------------------------
  logic        div_ge;
  logic [24:0] div_diff, rem_next;

  // Trial subtraction; remainder after subtracting is below the divisor so it fits 24 bits.
  always_comb begin
    div_ge   = rem_q >= {1'b0, mant_b_q};
    div_diff = div_ge ? (rem_q - {1'b0, mant_b_q}) : rem_q;
    rem_next = {div_diff[23:0], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // ROUND: denormalise if needed, round to nearest even, detect overflow
  // ---------------------------------------------------------------------------
  logic signed [9:0] shift_wide;
  logic [4:0]        sh;
  logic [9:0]        exp_field;
  logic [25:0]       q_sh;
  logic              lost, guard, rs, inc;
  logic [32:0]       wide;
  logic [31:0]       round_word;

  // Build the final rounded word from quotient, exponent and sticky.
  always_comb begin
    shift_wide = 10'sd1 - exp_q;
    sh         = 5'd0;
    exp_field  = exp_q;
    if (exp_q <= 10'sd0) begin
      sh        = (shift_wide > 10'sd26) ? 5'd26 : shift_wide[4:0];
      exp_field = 10'd0;
    end
    q_sh  = quo_q >> sh;
    lost  = |(quo_q & ~({26{1'b1}} << sh));
    guard = q_sh[1];
    rs    = q_sh[0] | lost | (|rem_q);
    inc   = guard & (rs | q_sh[2]);
    // Mantissa carry ripples into the exponent field (also subnormal -> min normal).
    wide  = {exp_field, q_sh[24:2]} + {32'd0, inc};
    if (wide[32:23] >= 10'd255) round_word = {sign_q, 8'hFF, 23'h0};
    else                        round_word = {sign_q, wide[30:0]};
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = special ? DONE : NORM;
      NORM:    state_next = DIV;
      DIV:     if (cnt_q == 5'd25) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Datapath registers, updated according to the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      mant_b_q    <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      delta       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q         <= alpha;
          b_q         <= bravo;
          sign_q      <= in_sign;
          div_by_zero <= special & spec_dbz;
          if (special) delta <= spec_word;
        end
        NORM: begin
          exp_q    <= norm_exp;
          rem_q    <= norm_rem;
          mant_b_q <= mant_nb;
          quo_q    <= '0;
          cnt_q    <= '0;
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[24:0], div_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        ROUND:   delta <= round_word;
        default: ;
      endcase
    end
  end

endmodule
